// File: rtl/lamp_fpu_sqrt_rndpack.sv
// Rounds (RNE), saturates and packs the sqrt result, then queues it for a ready/valid consumer.
// Latency: one cycle from valid_i to valid_o when the output buffer is empty.
// Backpressure: a DEPTH-entry buffer absorbs stalls; a result arriving while full and not popping is dropped (drop_o).
module lamp_fpu_sqrt_rndpack #(
  parameter int E_DW  = 8,
  parameter int F_DW  = 7,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 s_i,
  input  logic [E_DW-1:0]      e_i,
  input  logic [F_DW+4:0]      f_i,
  input  logic                 isToRound_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [E_DW+F_DW:0]   res_o,
  output logic                 inexact_o,
  output logic                 overflow_o,
  output logic                 drop_o,
  input  logic                 clr_flags_i
);

  localparam int W  = 1 + E_DW + F_DW;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic             lsb, guard, restSticky, roundUp;
  logic [F_DW+1:0]  mant;
  logic [E_DW-1:0]  expRnd;
  logic [F_DW-1:0]  fracRnd;
  logic             ovfEvt, inxEvt;
  logic [W-1:0]     resRnd;

  logic [W-1:0]     mem [DEPTH];
  logic [PW-1:0]    wrPtr, rdPtr;
  logic [CW-1:0]    count;
  logic             full, push, pop;

  // Round-to-nearest-even, carry renormalisation, saturation to infinity and packing.
  always_comb begin
    lsb        = f_i[4];
    guard      = f_i[3];
    restSticky = |f_i[2:0];
    roundUp    = isToRound_i & guard & (lsb | restSticky);
    mant       = {1'b0, f_i[F_DW+4:4]} + {{(F_DW+1){1'b0}}, roundUp};
    if (mant[F_DW+1]) begin
      // Carry-out: shifting right by one leaves an all-zero fraction.
      fracRnd = mant[F_DW:1];
      expRnd  = e_i + {{(E_DW-1){1'b0}}, 1'b1};
    end else begin
      fracRnd = mant[F_DW-1:0];
      expRnd  = e_i;
    end
    ovfEvt = isToRound_i & (&expRnd);
    if (ovfEvt) begin
      fracRnd = '0;
    end
    inxEvt = isToRound_i & (guard | restSticky);
    if (isToRound_i) begin
      resRnd = {s_i, expRnd, fracRnd};
    end else begin
      resRnd = {s_i, e_i, f_i[F_DW+3:4]};
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign valid_o = (count != '0);
  assign pop     = valid_o & ready_i;
  assign push    = valid_i & (~full | pop);
  // Head is only meaningful while valid; present zero otherwise so reset state is clean.
  assign res_o   = valid_o ? mem[rdPtr] : '0;

  // Buffer storage: write the rounded word at the tail on every accepted result.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= resRnd;
    end
  end

  // Pointer/occupancy control and drop pulse; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      drop_o <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      drop_o <= valid_i & full & ~pop;
    end
  end

  // Sticky exception flags: only accepted results contribute; clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst || clr_flags_i) begin
      inexact_o  <= 1'b0;
      overflow_o <= 1'b0;
    end else if (push) begin
      inexact_o  <= inexact_o | inxEvt;
      overflow_o <= overflow_o | ovfEvt;
    end
  end

endmodule
